counter_param: RTL and testbench
================================

COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 Parameter Width, default 32: bit width of Data_o and LoadData_i.
REQ-002 Parameter Init, default 8: value loaded on reset and on Clear_i.
REQ-003 Parameter Min, default 8: lower count bound, inclusive.
REQ-004 Parameter Max, default 64: upper count bound, inclusive.
REQ-005 Parameter Step, default 1: increment/decrement per enabled cycle.
REQ-006 Parameter Wrap, default 0: 0 = saturate at bounds, 1 = wrap between bounds.
REQ-007 Clk_i  input  1  single clock; all state updates on rising edge.
REQ-008 Reset_i  input  1  asynchronous, active-high reset.
REQ-009 En_i  input  1  count enable for one step this cycle.
REQ-010 Up_i  input  1  direction: 1 = count up, 0 = count down.
REQ-011 Load_i  input  1  synchronous load of LoadData_i.
REQ-012 LoadData_i  input  Width  load value.
REQ-013 Clear_i  input  1  synchronous return to Init.
REQ-014 Data_o  output  Width  registered counter value.
REQ-015 AtMax_o  output  1  combinational, Data_o == Max.
REQ-016 AtMin_o  output  1  combinational, Data_o == Min.
REQ-017 Limit_o  output  1  registered one-cycle pulse: the previous cycle's count step hit or crossed a bound.

Function
REQ-018 Legal parameters SHALL be Min <= Init <= Max <= 2^Width-1 and 1 <= Step <= Max-Min; elaboration SHALL fail otherwise.
REQ-019 Per-edge priority SHALL be Clear_i > Load_i > En_i > hold.
REQ-020 Clear_i SHALL set Data_o = Init and Limit_o = 0 on the next edge.
REQ-021 Load_i SHALL set Data_o = LoadData_i, clamped to Min if below Min and to Max if above Max, with Limit_o = 0.
REQ-022 En_i with Up_i = 1 SHALL compute Data_o + Step in Width+1 bits, so no modular overflow occurs.
REQ-023 En_i with Up_i = 0 SHALL compute Data_o - Step with a borrow check, so no modular underflow occurs.
REQ-024 Saturate mode, up step result > Max: Data_o SHALL become Max and Limit_o SHALL pulse.
REQ-025 Saturate mode, down step result < Min: Data_o SHALL become Min and Limit_o SHALL pulse.
REQ-026 Saturate mode, step result exactly equal to Max or Min: value SHALL be taken and Limit_o SHALL pulse.
REQ-027 Wrap mode, up step from Data_o == Max: Data_o SHALL become Min and Limit_o SHALL pulse.
REQ-028 Wrap mode, up step result > Max with Data_o < Max: Data_o SHALL become Max, without wrapping, and Limit_o SHALL pulse.
REQ-029 Wrap mode, down steps SHALL behave symmetrically to up steps, with Min wrapping to Max.
REQ-030 In-range step not reaching a bound: Data_o SHALL be updated by exactly Step, and Limit_o = 0.
REQ-031 No Clear_i, Load_i or En_i: Data_o SHALL hold and Limit_o = 0.
REQ-032 Invariant: Min <= Data_o <= Max SHALL hold in every cycle.
REQ-033 Latency: Data_o and Limit_o SHALL reflect inputs exactly one clock edge after sampling.

Reset
REQ-034 Reset_i = 1 SHALL immediately, without a clock edge, force Data_o = Init and Limit_o = 0.
REQ-035 Reset asserted mid-count SHALL override all inputs for as long as it is held.
REQ-036 After Reset_i deasserts, the first rising edge SHALL apply normal priority.

Verification (defaults: Init=8, Min=8, Max=64, Step=1, Wrap=0 unless stated)
REQ-037 Reset, then En_i = 1 and Up_i = 1 for 60 cycles -> Data_o runs 8..64, then holds at 64; Limit_o pulses once on 63->64 and on every later cycle it is held at 64.
REQ-038 Wrap=1, Data_o = 64, single up step -> Data_o = 8 with Limit_o = 1; then down step -> Data_o = 64 with Limit_o = 1.
REQ-039 Load_i with LoadData_i = 3, then 100, then 20 -> Data_o = 8, 64, 20 on consecutive cycles, with Limit_o = 0 throughout.
REQ-040 Clear_i, Load_i (LoadData_i = 30) and En_i all asserted together at Data_o = 40 -> Data_o = 8; Load_i and En_i alone -> Data_o = 30.
REQ-041 Step=5, Data_o = 62, up step -> Data_o = 64 (saturate) with Limit_o = 1; down step from 10 -> Data_o = 8 with Limit_o = 1.
REQ-042 Reset_i pulsed between clock edges during counting at Data_o = 37 -> Data_o = 8 before the next edge; invariant 8 <= Data_o <= 64 holds in all scenarios.

Source files
------------

// File: rtl/counter_param_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_param_if
// Brief    : Control/status bundle between a counter_param and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_param_if #(
    parameter int Width = 32
);
    logic             En_i;
    logic             Up_i;
    logic             Load_i;
    logic [Width-1:0] LoadData_i;
    logic             Clear_i;
    logic [Width-1:0] Data_o;
    logic             AtMax_o;
    logic             AtMin_o;
    logic             Limit_o;

    modport master (
        output En_i, Up_i, Load_i, LoadData_i, Clear_i,
        input  Data_o, AtMax_o, AtMin_o, Limit_o
    );

    modport slave (
        input  En_i, Up_i, Load_i, LoadData_i, Clear_i,
        output Data_o, AtMax_o, AtMin_o, Limit_o
    );
endinterface
`default_nettype wire

// File: rtl/counter_param.sv
`default_nettype none
// ============================================================================
// Module   : counter_param
// Brief    : Bounded up/down counter with load, clear, saturate or wrap mode.
// Revision : 1.0 - initial release
// ============================================================================
module counter_param #(
    parameter int unsigned Width = 32,
    parameter int unsigned Init  = 8,
    parameter int unsigned Min   = 8,
    parameter int unsigned Max   = 64,
    parameter int unsigned Step  = 1,
    parameter bit          Wrap  = 1'b0
) (
    input  wire logic          Clk_i,
    input  wire logic          Reset_i,
    counter_param_if.slave     bus
);
    localparam logic [Width-1:0] c_init   = Width'(Init);
    localparam logic [Width-1:0] c_min    = Width'(Min);
    localparam logic [Width-1:0] c_max    = Width'(Max);
    localparam logic [Width-1:0] c_step   = Width'(Step);
    localparam logic [Width:0]   c_max_x  = {1'b0, c_max};
    localparam logic [Width:0]   c_step_x = {1'b0, c_step};

    generate
        if (Width < 1) begin : g_bad_width
            $error("counter_param: Width must be at least 1");
        end
        if (Width < 32 && (Max >> Width) != 0) begin : g_bad_max_range
            $error("counter_param: Max does not fit in Width bits");
        end
        if (!(Min <= Init && Init <= Max)) begin : g_bad_init
            $error("counter_param: require Min <= Init <= Max");
        end
        if (Step < 1 || Step > (Max - Min)) begin : g_bad_step
            $error("counter_param: require 1 <= Step <= Max - Min");
        end
    endgenerate

    logic [Width-1:0] data_q, data_d;
    logic             limit_q, limit_d;

    logic [Width:0]   w_sum;
    logic             w_up_hit;
    logic [Width-1:0] w_diff;
    logic             w_borrow;
    logic             w_dn_hit;

    // Up path is one bit wider so the carry is part of the bound compare.
    assign w_sum    = {1'b0, data_q} + c_step_x;
    assign w_up_hit = (w_sum >= c_max_x);
    // A borrow means the true result is negative, hence below any Min.
    assign w_borrow = (data_q < c_step);
    assign w_diff   = data_q - c_step;
    assign w_dn_hit = w_borrow || (w_diff <= c_min);

    always_comb begin
        data_d  = data_q;
        limit_d = 1'b0;
        if (bus.Clear_i) begin
            data_d = c_init;
        end else if (bus.Load_i) begin
            if (bus.LoadData_i < c_min) begin
                data_d = c_min;
            end else if (bus.LoadData_i > c_max) begin
                data_d = c_max;
            end else begin
                data_d = bus.LoadData_i;
            end
        end else if (bus.En_i) begin
            if (bus.Up_i) begin
                if (Wrap && data_q == c_max) begin
                    data_d  = c_min;
                    limit_d = 1'b1;
                end else if (w_up_hit) begin
                    data_d  = c_max;
                    limit_d = 1'b1;
                end else begin
                    data_d = w_sum[Width-1:0];
                end
            end else begin
                if (Wrap && data_q == c_min) begin
                    data_d  = c_max;
                    limit_d = 1'b1;
                end else if (w_dn_hit) begin
                    data_d  = c_min;
                    limit_d = 1'b1;
                end else begin
                    data_d = w_diff;
                end
            end
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            data_q  <= c_init;
            limit_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            limit_q <= limit_d;
        end
    end

    assign bus.Data_o  = data_q;
    assign bus.Limit_o = limit_q;
    assign bus.AtMax_o = (data_q == c_max);
    assign bus.AtMin_o = (data_q == c_min);
endmodule
`default_nettype wire

// File: tb/tb_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_param
// Brief    : Directed self-checking bench for counter_param in three configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_param;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    counter_param_if #(.Width(32)) if_sat ();
    counter_param_if #(.Width(32)) if_wrap ();
    counter_param_if #(.Width(32)) if_s5 ();

    counter_param #(.Width(32), .Init(8), .Min(8), .Max(64), .Step(1), .Wrap(1'b0))
        u_sat  (.Clk_i(clk), .Reset_i(rst), .bus(if_sat));
    counter_param #(.Width(32), .Init(8), .Min(8), .Max(64), .Step(1), .Wrap(1'b1))
        u_wrap (.Clk_i(clk), .Reset_i(rst), .bus(if_wrap));
    counter_param #(.Width(32), .Init(8), .Min(8), .Max(64), .Step(5), .Wrap(1'b0))
        u_s5   (.Clk_i(clk), .Reset_i(rst), .bus(if_s5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_sat.En_i  = 0; if_sat.Up_i  = 0; if_sat.Load_i  = 0; if_sat.Clear_i  = 0; if_sat.LoadData_i  = 0;
        if_wrap.En_i = 0; if_wrap.Up_i = 0; if_wrap.Load_i = 0; if_wrap.Clear_i = 0; if_wrap.LoadData_i = 0;
        if_s5.En_i   = 0; if_s5.Up_i   = 0; if_s5.Load_i   = 0; if_s5.Clear_i   = 0; if_s5.LoadData_i   = 0;
    endtask

    initial begin
        int exp_d;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle_all();
        #1;
        chk("reset_data",  if_sat.Data_o, 8);
        chk("reset_limit", 32'(if_sat.Limit_o), 0);
        chk("reset_atmin", 32'(if_sat.AtMin_o), 1);
        chk("reset_atmax", 32'(if_sat.AtMax_o), 0);
        chk("reset_wrap",  if_wrap.Data_o, 8);
        chk("reset_s5",    if_s5.Data_o, 8);
        #2 rst = 1'b0;

        // Saturating run from 8 to 64, then pinned at 64.
        if_sat.En_i = 1; if_sat.Up_i = 1;
        for (int k = 1; k <= 60; k++) begin
            step();
            exp_d = (8 + k > 64) ? 64 : 8 + k;
            chk("sat_run_data",  if_sat.Data_o, 32'(exp_d));
            chk("sat_run_limit", 32'(if_sat.Limit_o), (8 + k >= 64) ? 1 : 0);
            chk("sat_run_inv", 32'(if_sat.Data_o >= 8 && if_sat.Data_o <= 64), 1);
        end
        chk("sat_atmax", 32'(if_sat.AtMax_o), 1);
        idle_all();

        // Load clamping.
        if_sat.Load_i = 1; if_sat.LoadData_i = 3;
        step();
        chk("load3_data", if_sat.Data_o, 8);
        chk("load3_limit", 32'(if_sat.Limit_o), 0);
        if_sat.LoadData_i = 100;
        step();
        chk("load100_data", if_sat.Data_o, 64);
        chk("load100_limit", 32'(if_sat.Limit_o), 0);
        if_sat.LoadData_i = 20;
        step();
        chk("load20_data", if_sat.Data_o, 20);
        chk("load20_limit", 32'(if_sat.Limit_o), 0);
        idle_all();
        step();
        chk("hold_data", if_sat.Data_o, 20);
        chk("hold_limit", 32'(if_sat.Limit_o), 0);

        // Priority: Clear over Load over En.
        if_sat.Load_i = 1; if_sat.LoadData_i = 40;
        step();
        chk("load40_data", if_sat.Data_o, 40);
        if_sat.Clear_i = 1; if_sat.LoadData_i = 30; if_sat.En_i = 1; if_sat.Up_i = 1;
        step();
        chk("prio_clear_data", if_sat.Data_o, 8);
        chk("prio_clear_limit", 32'(if_sat.Limit_o), 0);
        if_sat.Clear_i = 0;
        step();
        chk("prio_load_data", if_sat.Data_o, 30);
        if_sat.Load_i = 0; if_sat.Up_i = 0;
        step();
        chk("down_inrange_data", if_sat.Data_o, 29);
        chk("down_inrange_limit", 32'(if_sat.Limit_o), 0);

        // Down to exactly Min, then below.
        idle_all();
        if_sat.Load_i = 1; if_sat.LoadData_i = 9;
        step();
        if_sat.Load_i = 0; if_sat.En_i = 1; if_sat.Up_i = 0;
        step();
        chk("down_exact_min_data", if_sat.Data_o, 8);
        chk("down_exact_min_limit", 32'(if_sat.Limit_o), 1);
        step();
        chk("down_sat_min_data", if_sat.Data_o, 8);
        chk("down_sat_min_limit", 32'(if_sat.Limit_o), 1);
        idle_all();
        step();
        chk("limit_clears", 32'(if_sat.Limit_o), 0);

        // Wrap mode.
        if_wrap.En_i = 1; if_wrap.Up_i = 1;
        step();
        chk("wrap_up_inrange", if_wrap.Data_o, 9);
        chk("wrap_up_inrange_limit", 32'(if_wrap.Limit_o), 0);
        if_wrap.En_i = 0; if_wrap.Load_i = 1; if_wrap.LoadData_i = 64;
        step();
        chk("wrap_load64", if_wrap.Data_o, 64);
        if_wrap.Load_i = 0; if_wrap.En_i = 1; if_wrap.Up_i = 1;
        step();
        chk("wrap_up_data", if_wrap.Data_o, 8);
        chk("wrap_up_limit", 32'(if_wrap.Limit_o), 1);
        if_wrap.Up_i = 0;
        step();
        chk("wrap_dn_data", if_wrap.Data_o, 64);
        chk("wrap_dn_limit", 32'(if_wrap.Limit_o), 1);
        if_wrap.En_i = 0; if_wrap.Load_i = 1; if_wrap.LoadData_i = 63;
        step();
        if_wrap.Load_i = 0; if_wrap.En_i = 1; if_wrap.Up_i = 1;
        step();
        chk("wrap_reach_max_data", if_wrap.Data_o, 64);
        chk("wrap_reach_max_limit", 32'(if_wrap.Limit_o), 1);
        idle_all();

        // Step of 5.
        if_s5.Load_i = 1; if_s5.LoadData_i = 62;
        step();
        if_s5.Load_i = 0; if_s5.En_i = 1; if_s5.Up_i = 1;
        step();
        chk("s5_up_sat_data", if_s5.Data_o, 64);
        chk("s5_up_sat_limit", 32'(if_s5.Limit_o), 1);
        if_s5.En_i = 0; if_s5.Load_i = 1; if_s5.LoadData_i = 10;
        step();
        if_s5.Load_i = 0; if_s5.En_i = 1; if_s5.Up_i = 0;
        step();
        chk("s5_dn_sat_data", if_s5.Data_o, 8);
        chk("s5_dn_sat_limit", 32'(if_s5.Limit_o), 1);
        if_s5.En_i = 0; if_s5.Load_i = 1; if_s5.LoadData_i = 20;
        step();
        if_s5.Load_i = 0; if_s5.En_i = 1; if_s5.Up_i = 1;
        step();
        chk("s5_up_inrange_data", if_s5.Data_o, 25);
        chk("s5_up_inrange_limit", 32'(if_s5.Limit_o), 0);
        idle_all();

        // Asynchronous reset mid-count.
        if_sat.Load_i = 1; if_sat.LoadData_i = 30;
        step();
        if_sat.Load_i = 0; if_sat.En_i = 1; if_sat.Up_i = 1;
        for (int k = 0; k < 7; k++) step();
        chk("pre_reset_data", if_sat.Data_o, 37);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_data", if_sat.Data_o, 8);
        chk("async_reset_limit", 32'(if_sat.Limit_o), 0);
        step();
        chk("reset_held_data", if_sat.Data_o, 8);
        #2 rst = 1'b0;
        step();
        chk("post_reset_step", if_sat.Data_o, 9);
        chk("post_reset_inv", 32'(if_sat.Data_o >= 8 && if_sat.Data_o <= 64), 1);
        idle_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
